// File: rtl/svnes_serial_pkg.sv
// +----------------------------------------------------------------------+
// | svnes_serial_pkg: shared types for the serial transmit/receive path  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package svnes_serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } uart_state_t;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int n, input int parity, input int stop_n);
    return 1 + n + parity + stop_n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/baud_tick.sv
// +----------------------------------------------------------------------+
// | baud_tick: modulo-CLK_DIV counter with clear and a one-cycle tick    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module baud_tick #(
  parameter int CLK_DIV = 16,
  parameter int CW      = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          tick
);

  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || (count_q == C_LAST)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  // Tick marks the final cycle of a bit period.
  assign tick  = !clear && (count_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_drain.sv
// +----------------------------------------------------------------------+
// | uart_tx_drain: pops a FWFT FIFO and sends each word as a UART frame  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_drain
  import svnes_serial_pkg::*;
#(
  parameter int N       = 8,
  parameter int CLK_DIV = 16,
  parameter int PARITY  = 0,
  parameter int STOP_N  = 1
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         empty,
  input  logic [N-1:0] in,
  output logic         rdack,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(N);

  localparam logic [CW-1:0] C_PRE_LAST = CW'(CLK_DIV - 2);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(N - 1);
  localparam logic [BW-1:0] C_LAST_STP = BW'(STOP_N - 1);

  uart_state_t   state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic          par_q, par_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          rdack_q, rdack_d;
  logic          done_q, done_d;

  logic [CW-1:0] baud_count;
  logic          baud_tick_w;
  logic          load;

  baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   (state_q == IDLE),
    .count   (baud_count),
    .tick    (baud_tick_w)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    rdack_d = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        load   = !empty;
      end
      START: begin
        if (baud_tick_w) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_tick_w) begin
          if (bit_q == C_LAST_BIT) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      PAR: begin
        if (baud_tick_w) begin
          state_d = STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
      end
      STOP: begin
        // done is registered, so raise it one cycle ahead of the frame end.
        done_d = (bit_q == C_LAST_STP) && (baud_count == C_PRE_LAST);
        if (baud_tick_w) begin
          if (bit_q == C_LAST_STP) begin
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
              bit_d   = '0;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Shared by the idle start and the back-to-back start at frame end.
    if (load) begin
      state_d = START;
      shift_d = in;
      par_d   = ^in;
      bit_d   = '0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      rdack_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rdack_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rdack_q <= rdack_d;
      done_q  <= done_d;
    end
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign rdack = rdack_q;
  assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
// +----------------------------------------------------------------------+
// | tb_uart_tx_drain: three configurations against a frame-level model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_drain;

  localparam int NI = 3;
  localparam int CD [NI] = '{4, 4, 2};
  localparam int PB [NI] = '{0, 1, 1};
  localparam int SN [NI] = '{1, 1, 2};
  localparam int RL = 200;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic [NI-1:0] empty_v = '1;
  logic [7:0]    in_v [NI];
  logic [NI-1:0] tx_v, busy_v, rdack_v, done_v;

  logic [7:0] envq [NI][$];
  logic [7:0] mirq [NI][$];
  logic [3:0] expq [NI][$];
  logic [3:0] rec  [NI][RL+1];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      uart_tx_drain #(
        .N       (8),
        .CLK_DIV (CD[g]),
        .PARITY  (PB[g]),
        .STOP_N  (SN[g])
      ) u_dut (
        .clk     (clk),
        .n_reset (n_reset),
        .empty   (empty_v[g]),
        .in      (in_v[g]),
        .rdack   (rdack_v[g]),
        .tx      (tx_v[g]),
        .busy    (busy_v[g]),
        .done    (done_v[g])
      );
    end
  endgenerate

  task automatic push(input int i, input logic [7:0] w);
    envq[i].push_back(w);
    mirq[i].push_back(w);
  endtask

  // Expected per-cycle {tx,busy,rdack,done} for one whole frame.
  function automatic void build_frame(input int i, input logic [7:0] w);
    logic bits [$];
    int   nb;
    bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) bits.push_back(w[b]);
    if (PB[i] != 0) bits.push_back(^w);
    for (int s = 0; s < SN[i]; s++) bits.push_back(1'b1);
    nb = bits.size();
    for (int j = 0; j < nb; j++) begin
      for (int c = 0; c < CD[i]; c++) begin
        expq[i].push_back({bits[j], 1'b1, (j == 0 && c == 0), (j == nb - 1 && c == CD[i] - 1)});
      end
    end
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic int cnt(input int i, input int sel, input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi; k++) s += rec[i][k][sel] ? 1 : 0;
    return s;
  endfunction

  function automatic int firstk(input int i, input int sel, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) if (rec[i][k][sel]) return k;
    return -1;
  endfunction

  // Cycle k = the cycle following the k-th rising edge after the call point.
  task automatic record(input int n);
    @(negedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) rec[i][k] = {tx_v[i], busy_v[i], rdack_v[i], done_v[i]};
    end
  endtask

  // Environment FIFO plus per-cycle comparison against the frame model.
  initial begin
    logic [3:0] want;
    logic [3:0] got;
    for (int i = 0; i < NI; i++) in_v[i] = 8'h00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!n_reset) expq[i].delete();
        want = (expq[i].size() != 0) ? expq[i][0] : 4'b1000;
        got  = {tx_v[i], busy_v[i], rdack_v[i], done_v[i]};
        n_total++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL cycle_model inst=%0d t=%0t got(tx,busy,rdack,done)=%b want=%b", i, $time, got, want);
        end
        if (expq[i].size() != 0) void'(expq[i].pop_front());
        if (rdack_v[i] && envq[i].size() != 0) void'(envq[i].pop_front());
        if (n_reset && expq[i].size() == 0 && mirq[i].size() != 0) build_frame(i, mirq[i].pop_front());
        empty_v[i] = (envq[i].size() == 0);
        in_v[i]    = empty_v[i] ? 8'($urandom) : envq[i][0];
      end
    end
  end

  initial begin
    logic [9:0] pat10;
    logic [7:0] pat8;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({tx_v, busy_v, rdack_v, done_v}), 12'hE00);
    #2 n_reset = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    // Single frames, parity frames, 2-cycle bit period with 2 stop bits.
    push(0, 8'hA5);
    push(1, 8'hA5); push(1, 8'h01);
    push(2, 8'h3C); push(2, 8'hC3);
    record(100);
    for (int b = 0; b < 10; b++) pat10[b] = rec[0][4*b+2][3];
    chk("a5_bits", int'(pat10), 10'h34A);
    chk("a5_rdack_count", cnt(0, 1, 1, 100), 1);
    chk("a5_rdack_cycle", firstk(0, 1, 1, 100), 1);
    chk("a5_done_cycle", firstk(0, 0, 1, 100), 40);
    chk("a5_done_count", cnt(0, 0, 1, 100), 1);
    chk("a5_busy_end", int'({rec[0][40][2], rec[0][41][2]}), 2);
    chk("par_a5", int'(rec[1][38][3]), 0);
    chk("par_01", int'(rec[1][82][3]), 1);
    chk("par_done1", firstk(1, 0, 1, 100), 44);
    chk("par_done2", firstk(1, 0, 45, 100), 88);
    chk("par_rdack2", firstk(1, 1, 2, 100), 45);
    chk("s2_done1", firstk(2, 0, 1, 100), 24);
    chk("s2_done2", firstk(2, 0, 25, 100), 48);
    chk("s2_busy_run", cnt(2, 2, 1, 48), 48);
    chk("s2_busy_end", int'(rec[2][49][2]), 0);
    for (int b = 0; b < 8; b++) pat8[b] = rec[2][4+2*b][3];
    chk("s2_data1", int'(pat8), 8'h3C);
    for (int b = 0; b < 8; b++) pat8[b] = rec[2][28+2*b][3];
    chk("s2_data2", int'(pat8), 8'hC3);

    // Three queued words drained back to back.
    @(posedge clk); #2;
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    record(130);
    chk("b2b_busy_run", cnt(0, 2, 1, 120), 120);
    chk("b2b_busy_fall", int'(rec[0][121][2]), 0);
    chk("b2b_rdack_count", cnt(0, 1, 1, 130), 3);
    chk("b2b_done_count", cnt(0, 0, 1, 130), 3);
    chk("b2b_no_gap", int'(rec[0][41][3:1]), 3'b011);
    chk("b2b_done3", firstk(0, 0, 81, 130), 120);

    // Long idle, then a zero word.
    @(posedge clk); #2;
    record(100);
    chk("idle_tx_high", cnt(0, 3, 1, 100), 100);
    chk("idle_busy", cnt(0, 2, 1, 100), 0);
    chk("idle_rdack", cnt(0, 1, 1, 100), 0);
    @(posedge clk); #2;
    push(0, 8'h00);
    record(45);
    chk("zero_start", int'(rec[0][1][3:1]), 3'b011);
    chk("zero_last_data", int'(rec[0][36][3]), 0);
    chk("zero_stop", int'(rec[0][37][3]), 1);
    chk("zero_done", firstk(0, 0, 1, 45), 40);

    // Asynchronous reset in the middle of the data bits.
    @(posedge clk); #2;
    push(0, 8'hFF); push(0, 8'h5A);
    @(negedge clk);
    repeat (15) @(posedge clk);
    #3 n_reset = 1'b0;
    #1;
    chk("midreset_outputs", int'({tx_v[0], busy_v[0], rdack_v[0], done_v[0]}), 4'b1000);
    repeat (3) @(posedge clk);
    #3 n_reset = 1'b1;
    record(45);
    chk("after_reset_start", int'(rec[0][1][3:1]), 3'b011);
    chk("after_reset_rdack", cnt(0, 1, 1, 45), 1);
    chk("after_reset_bits", int'({rec[0][10][3], rec[0][6][3]}), 2'b10);
    chk("after_reset_done", firstk(0, 0, 1, 45), 40);

    repeat (10) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
